// File: rtl/median_blur_rank_pipe.sv
// 3x3 rank-order filter: odd-even transposition sort split over three
// registered stages, selecting min/median/max (or bypassing the centre pixel).
module median_blur_rank_pipe #(
    parameter int DATA_W    = 8,
    parameter bit SIGNED_PX = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9*DATA_W-1:0] px_in,
    input  logic [3:0]          rank,
    input  logic                bypass,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   out,
    output logic                out_valid,
    input  logic                out_ready
);

    typedef logic [8:0][DATA_W-1:0] win_t;

    function automatic logic ge(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED_PX)
            return $signed(a) >= $signed(b);
        return a >= b;
    endfunction

    // One transposition layer; pairs never overlap, so every compare reads the layer input.
    // The upper slot is in_1; ties keep it in place as the high output.
    function automatic win_t cas_layer(input win_t a, input int odd);
        win_t r;
        r = a;
        for (int i = 0; i < 8; i++) begin
            if ((i % 2) == odd) begin
                if (ge(a[i+1], a[i])) begin
                    r[i]   = a[i];
                    r[i+1] = a[i+1];
                end else begin
                    r[i]   = a[i+1];
                    r[i+1] = a[i];
                end
            end
        end
        return r;
    endfunction

    // Three layers per stage; nine alternating layers fully sort nine values.
    function automatic win_t sort3(input win_t a, input int first);
        return cas_layer(cas_layer(cas_layer(a, first), 1 - first), first);
    endfunction

    win_t              in_win;
    win_t              s3_sorted;
    logic [3:0]        rank_sat;
    logic              en;

    win_t              s1_data;
    logic              s1_valid;
    logic [3:0]        s1_rank;
    logic              s1_bypass;
    logic [DATA_W-1:0] s1_centre;

    win_t              s2_data;
    logic              s2_valid;
    logic [3:0]        s2_rank;
    logic              s2_bypass;
    logic [DATA_W-1:0] s2_centre;

    assign in_win    = px_in;
    assign rank_sat  = (rank > 4'd8) ? 4'd8 : rank;
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign s3_sorted = sort3(s2_data, 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_data   <= '0;
            s1_valid  <= 1'b0;
            s1_rank   <= '0;
            s1_bypass <= 1'b0;
            s1_centre <= '0;
            s2_data   <= '0;
            s2_valid  <= 1'b0;
            s2_rank   <= '0;
            s2_bypass <= 1'b0;
            s2_centre <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            s1_data   <= sort3(in_win, 0);
            s1_valid  <= in_valid;
            s1_rank   <= rank_sat;
            s1_bypass <= bypass;
            s1_centre <= bypass ? in_win[4] : '0;
            s2_data   <= sort3(s1_data, 1);
            s2_valid  <= s1_valid;
            s2_rank   <= s1_rank;
            s2_bypass <= s1_bypass;
            s2_centre <= s1_centre;
            out_valid <= s2_valid;
            // Bubbles leave the last result on out.
            if (s2_valid)
                out <= s2_bypass ? s2_centre : s3_sorted[s2_rank];
        end
    end

endmodule

// File: tb/tb_median_blur_rank_pipe.sv
// Directed bench for median_blur_rank_pipe: default 8-bit unsigned instance
// plus a 12-bit signed instance for the signed window and mid-stream reset.
module tb_median_blur_rank_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] px_in;
    logic [3:0]  rank;
    logic        bypass, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  out;

    logic [107:0] px_s;
    logic [3:0]   rank_s;
    logic         bypass_s, in_valid_s, in_ready_s, out_valid_s, out_ready_s;
    logic [11:0]  out_s;

    int total = 0;
    int bad   = 0;

    logic [71:0] win_q[$];
    logic [3:0]  rank_q[$];
    logic        byp_q[$];
    int          exp_q[$];
    int          got[$];
    int          lat;

    always #5 clk = ~clk;

    median_blur_rank_pipe dut (
        .clk(clk), .reset(reset), .px_in(px_in), .rank(rank), .bypass(bypass),
        .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    median_blur_rank_pipe #(.DATA_W(12), .SIGNED_PX(1'b1)) dut_s (
        .clk(clk), .reset(reset), .px_in(px_s), .rank(rank_s), .bypass(bypass_s),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .out(out_s), .out_valid(out_valid_s),
        .out_ready(out_ready_s)
    );

    // Record each output transfer; negedge is clear of the active edge.
    always @(negedge clk)
        if (!reset && out_valid && out_ready)
            got.push_back(int'(out));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] mk(input int p1, input int p2, input int p3, input int p4,
                                       input int p5, input int p6, input int p7, input int p8,
                                       input int p9);
        return {p9[7:0], p8[7:0], p7[7:0], p6[7:0], p5[7:0], p4[7:0], p3[7:0], p2[7:0], p1[7:0]};
    endfunction

    task automatic add(input logic [71:0] w, input logic [3:0] r, input logic b, input int e);
        win_q.push_back(w);
        rank_q.push_back(r);
        byp_q.push_back(b);
        exp_q.push_back(e);
    endtask

    // Streams the queued windows; out_ready is low for cycles [stall_at, stall_at+stall_len).
    task automatic run(input string name, input int stall_at, input int stall_len,
                       input int stall_val, output int first_lat);
        int idx = 0;
        int cyc = 0;
        logic acc;
        got.delete();
        first_lat = -1;
        while (cyc < 200 && !(idx == win_q.size() && got.size() == exp_q.size())) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (idx < win_q.size()) begin
                in_valid = 1'b1;
                px_in    = win_q[idx];
                rank     = rank_q[idx];
                bypass   = byp_q[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (first_lat < 0 && out_valid)
                first_lat = cyc;
            if (!out_ready) begin
                chk({name, "_stall_rdy"}, in_ready, 0);
                chk({name, "_stall_out"}, out, stall_val);
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc)
                idx++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({name, "_count"}, got.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got.size())
                chk($sformatf("%s_res%0d", name, i), got[i], exp_q[i]);
        win_q.delete();
        rank_q.delete();
        byp_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [71:0] w1;
        w1 = mk(9, 1, 8, 2, 7, 3, 6, 4, 5);

        reset = 1'b1;
        px_in = '0; rank = 4'd4; bypass = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        px_s = '0; rank_s = 4'd4; bypass_s = 1'b0; in_valid_s = 1'b0; out_ready_s = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // Median of the 1..9 window on three consecutive cycles.
        for (int i = 0; i < 3; i++) add(w1, 4'd4, 1'b0, 5);
        run("median", 1000, 0, 0, lat);
        chk("median_lat", lat, 3);
        chk("median_idle_valid", out_valid, 0);
        chk("median_hold_out", out, 5);

        // Rank sweep including the saturated value 12.
        add(w1, 4'd0, 1'b0, 1);
        add(w1, 4'd8, 1'b0, 9);
        add(w1, 4'd12, 1'b0, 9);
        add(w1, 4'd2, 1'b0, 3);
        add(w1, 4'd15, 1'b0, 9);
        run("rank", 1000, 0, 0, lat);

        // Ties: sorted duplicates are 0,0,0,0,3,3,3,7,7 so index 4 is 3.
        add(mk(170, 170, 170, 170, 170, 170, 170, 170, 170), 4'd4, 1'b0, 170);
        add(mk(3, 3, 3, 0, 0, 0, 0, 7, 7), 4'd4, 1'b0, 3);
        add(mk(3, 3, 3, 0, 0, 0, 0, 7, 7), 4'd3, 1'b0, 0);
        run("dups", 1000, 0, 0, lat);

        // Bypass ignores rank and sorting, then sorting resumes.
        add(mk(255, 255, 255, 255, 60, 255, 255, 255, 255), 4'd8, 1'b1, 60);
        add(w1, 4'd4, 1'b0, 5);
        run("bypass", 1000, 0, 0, lat);
        chk("bypass_lat", lat, 3);

        // Back-pressure: four stall cycles while the second result sits on out.
        add(w1, 4'd0, 1'b0, 1);
        add(w1, 4'd8, 1'b0, 9);
        add(mk(170, 170, 170, 170, 170, 170, 170, 170, 170), 4'd4, 1'b0, 170);
        add(mk(3, 3, 3, 0, 0, 0, 0, 7, 7), 4'd7, 1'b0, 7);
        add(w1, 4'd3, 1'b0, 4);
        add(w1, 4'd5, 1'b0, 6);
        run("stall", 4, 4, 9, lat);

        // Signed 12-bit window: -5,-1,0,3,-2048,2047,7,-7,1 has median 0.
        px_s = {12'h001, 12'hFF9, 12'h007, 12'h7FF, 12'h800, 12'h003, 12'h000, 12'hFFF, 12'hFFB};
        rank_s = 4'd4;
        in_valid_s = 1'b1;
        tick();
        in_valid_s = 1'b0;
        tick();
        tick();
        chk("signed_valid", out_valid_s, 1);
        chk("signed_median", out_s, 0);
        rank_s = 4'd8;
        in_valid_s = 1'b1;
        tick();
        in_valid_s = 1'b0;
        tick();
        tick();
        chk("signed_max", out_s, 12'h7FF);
        tick();

        // Two windows in flight, then reset before either reaches out.
        rank_s = 4'd0;
        in_valid_s = 1'b1;
        tick();
        tick();
        in_valid_s = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_mid_valid", out_valid_s, 0);
        chk("rst_mid_out", out_s, 0);
        chk("rst_mid_ready", in_ready_s, 1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("no_stale_%0d", i), out_valid_s, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
